cmp_seg_display: RTL and testbench

Display stage directly downstream of the 4-bit comparator on the board. Takes the two switch operands (A, B) and the comparator's one-hot result, filters out switch bounce, and drives a 4-digit multiplexed 7-segment display showing A, the relation symbol, B, and a 4-bit count of result changes. Flags a non-one-hot comparator result.

---
 rtl/cmp_disp_pkg.sv | 78 +++++++
 rtl/stable_latch.sv | 40 ++++
 rtl/cmp_seg_display.sv | 124 ++++++++++++
 tb/tb_cmp_seg_display.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cmp_disp_pkg.sv
// rtl/cmp_disp_pkg.sv - shared codes, segment patterns and scan states for the comparator display
package cmp_disp_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    // Segment order is {dp,g,f,e,d,c,b,a}, active-high.
    localparam logic [7:0] SEG_GT   = 8'h46;
    localparam logic [7:0] SEG_EQ   = 8'h48;
    localparam logic [7:0] SEG_LT   = 8'h70;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_ERR  = 8'hF9;

    typedef enum logic [1:0] {
        DIG3 = 2'd0,
        DIG2 = 2'd1,
        DIG1 = 2'd2,
        DIG0 = 2'd3
    } scan_state_t;

    function automatic logic [7:0] hex_font(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'h3F;
            4'h1:    pat = 8'h06;
            4'h2:    pat = 8'h5B;
            4'h3:    pat = 8'h4F;
            4'h4:    pat = 8'h66;
            4'h5:    pat = 8'h6D;
            4'h6:    pat = 8'h7D;
            4'h7:    pat = 8'h07;
            4'h8:    pat = 8'h7F;
            4'h9:    pat = 8'h6F;
            4'hA:    pat = 8'h77;
            4'hB:    pat = 8'h7C;
            4'hC:    pat = 8'h39;
            4'hD:    pat = 8'h5E;
            4'hE:    pat = 8'h79;
            default: pat = 8'h71;
        endcase
        return pat;
    endfunction

    function automatic logic cmp_is_valid(input logic [2:0] r);
        return (r == CMP_GT) || (r == CMP_EQ) || (r == CMP_LT);
    endfunction

    // The all-zero code is the power-up value, so it is shown as a dash, not an error.
    function automatic logic cmp_is_error(input logic [2:0] r);
        return !cmp_is_valid(r) && (r != CMP_NONE);
    endfunction

    function automatic logic [7:0] cmp_symbol(input logic [2:0] r);
        logic [7:0] pat;
        case (r)
            CMP_GT:   pat = SEG_GT;
            CMP_EQ:   pat = SEG_EQ;
            CMP_LT:   pat = SEG_LT;
            CMP_NONE: pat = SEG_DASH;
            default:  pat = SEG_ERR;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] digit_enable(input scan_state_t st);
        logic [3:0] en;
        case (st)
            DIG3:    en = 4'b1000;
            DIG2:    en = 4'b0100;
            DIG1:    en = 4'b0010;
            default: en = 4'b0001;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/stable_latch.sv
// rtl/stable_latch.sv - input sampler with stability counter; pulses once per stable period
module stable_latch #(
    parameter int W             = 11,
    parameter int STABLE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         latch
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  s;
    logic [CW-1:0] cnt;
    logic          same;

    assign same  = (d == s);
    // Fires only on the step into saturation, so a held input latches exactly once.
    assign latch = same && (cnt == CNT_PRE);
    assign q     = s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= '0;
            cnt <= '0;
        end else begin
            s <= d;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_seg_display.sv
// rtl/cmp_seg_display.sv - debounced comparator result shown on a 4-digit multiplexed 7-segment display
module cmp_seg_display #(
    parameter int SCAN_DIV      = 100000,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din1,
    input  logic [3:0] din2,
    input  logic [2:0] cmp,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [3:0] chg_cnt,
    output logic       err
);

    import cmp_disp_pkg::*;

    localparam int               DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [10:0]      sample;
    logic             latch;
    logic [3:0]       new_a;
    logic [3:0]       new_b;
    logic [2:0]       new_r;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [2:0]       r_q;
    logic             err_q;
    logic [3:0]       chg_q;
    logic             counts_change;
    logic [DIV_W-1:0] div;
    logic             div_tc;
    scan_state_t      state;
    scan_state_t      state_next;
    logic [7:0]       seg_next;
    logic [3:0]       an_next;

    stable_latch #(
        .W             (11),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stable (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({din1, din2, cmp}),
        .q     (sample),
        .latch (latch)
    );

    assign new_a = sample[10:7];
    assign new_b = sample[6:3];
    assign new_r = sample[2:0];

    // Only a move between two genuine one-hot results is a change worth counting.
    assign counts_change = cmp_is_valid(r_q) && cmp_is_valid(new_r) && (r_q != new_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= CMP_NONE;
            err_q <= 1'b0;
            chg_q <= '0;
        end else if (latch) begin
            a_q   <= new_a;
            b_q   <= new_b;
            r_q   <= new_r;
            err_q <= cmp_is_error(new_r);
            if (counts_change) begin
                chg_q <= chg_q + 1'b1;
            end
        end
    end

    assign div_tc = (div == DIV_LAST);

    always_comb begin
        state_next = state;
        if (div_tc) begin
            case (state)
                DIG3:    state_next = DIG2;
                DIG2:    state_next = DIG1;
                DIG1:    state_next = DIG0;
                default: state_next = DIG3;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            state <= DIG3;
        end else begin
            div   <= div_tc ? '0 : div + 1'b1;
            state <= state_next;
        end
    end

    // Output registers follow the current digit, so they trail the scan state by one edge.
    always_comb begin
        an_next = digit_enable(state);
        case (state)
            DIG3:    seg_next = hex_font(a_q);
            DIG2:    seg_next = cmp_symbol(r_q);
            DIG1:    seg_next = hex_font(b_q);
            default: seg_next = hex_font(chg_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= '0;
            an  <= '0;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

    assign chg_cnt = chg_q;
    assign err     = err_q;

endmodule

// File: tb/tb_cmp_seg_display.sv
// tb/tb_cmp_seg_display.sv - randomized self-checking bench for cmp_seg_display
module tb_cmp_seg_display;

    localparam int SCAN_DIV      = 4;
    localparam int STABLE_CYCLES = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din1  = 4'h0;
    logic [3:0] din2  = 4'h0;
    logic [2:0] cmp   = 3'b000;
    logic [7:0] seg;
    logic [3:0] an;
    logic [3:0] chg_cnt;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  ma, mb, mchg;
    logic [2:0]  mr;
    logic        merr;
    int          edge_n;
    logic [10:0] hist[$];
    logic [7:0]  font_tbl[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [2:0]  valid_codes[3] = '{3'b100, 3'b010, 3'b001};

    cmp_seg_display #(
        .SCAN_DIV      (SCAN_DIV),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din1    (din1),
        .din2    (din2),
        .cmp     (cmp),
        .seg     (seg),
        .an      (an),
        .chg_cnt (chg_cnt),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", tag, got, exp, edge_n, $time);
        end
    endtask

    function automatic logic [7:0] sym_of(input logic [2:0] r);
        if (r == 3'b000) return 8'h40;
        if ($countones(r) != 1) return 8'hF9;
        if (r[2]) return 8'h46;
        if (r[1]) return 8'h48;
        return 8'h70;
    endfunction

    task automatic model_reset();
        ma = 0; mb = 0; mr = 0; mchg = 0; merr = 0; edge_n = 0;
        hist.delete();
        hist.push_back(11'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, seg, 8'h00);
        check({tag, "_an"}, an, 4'b0000);
        check({tag, "_chg"}, chg_cnt, 4'h0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // Called just after a rising edge: present the inputs, advance one edge, compare.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        logic [7:0]  es;
        logic [3:0]  ea;
        logic [10:0] nv;
        int          digit;
        int          run;
        din1 = a; din2 = b; cmp = c;
        @(posedge clk);
        edge_n++;
        digit = ((edge_n - 1) / SCAN_DIV) % 4;
        ea = 4'b1000 >> digit;
        case (digit)
            0:       es = font_tbl[ma];
            1:       es = sym_of(mr);
            2:       es = font_tbl[mb];
            default: es = font_tbl[mchg];
        endcase
        nv = {a, b, c};
        hist.push_back(nv);
        if (hist.size() > STABLE_CYCLES + 2) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != nv) break;
            run++;
        end
        if (run == STABLE_CYCLES + 1) begin
            if ($countones(mr) == 1 && $countones(c) == 1 && mr != c) mchg = mchg + 4'd1;
            ma = a; mb = b; mr = c;
            merr = (c != 3'b000) && ($countones(c) != 1);
        end
        #1;
        check("seg", seg, es);
        check("an", an, ea);
        check("chg_cnt", chg_cnt, mchg);
        check("err", err, merr);
    endtask

    task automatic hold(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) apply(a, b, c);
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [2:0] rc;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        hold(4'h9, 4'h3, 3'b100, 24);
        for (int i = 0; i < 10; i++) hold(4'h9, (i % 2 == 1) ? 4'h5 : 4'h3, 3'b100, 2);
        hold(4'h3, 4'h9, 3'b001, 20);

        for (int i = 0; i < 16; i++) begin
            hold(4'($urandom_range(15)), 4'($urandom_range(15)), (i % 2 == 0) ? 3'b100 : 3'b001, 10);
        end

        hold(4'h7, 4'h2, 3'b110, 12);
        hold(4'h7, 4'h2, 3'b010, 12);

        for (int k = 0; k < 300; k++) begin
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rc = ($urandom_range(3) != 0) ? valid_codes[$urandom_range(2)] : 3'($urandom_range(7));
            hold(ra, rb, rc, $urandom_range(1, 8));
        end

        hold(4'h1, 4'h1, 3'b001, 8);
        hold(4'h5, 4'h5, 3'b010, STABLE_CYCLES);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        #1 rst_n = 1'b1;
        model_reset();
        hold(4'h5, 4'h5, 3'b010, 20);
        hold(4'hA, 4'hF, 3'b100, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
